// File: rtl/noc_arb_pkg.sv
// noc_arb_pkg: shared state type and one-hot decode for the output arbiter.
//    arb_state_t   - IDLE (arbitrating) / LOCKED (wormhole owner holds the output)
//    onehot_to_idx - index of the set bit of a one-hot (or zero) vector of up to 8 bits
package noc_arb_pkg;

   typedef enum logic {IDLE, LOCKED} arb_state_t;

   localparam int MAX_INPUTS = 8;

   // OR of bit indices: exact for one-hot, 0 for an all-zero vector.
   function automatic logic [2:0] onehot_to_idx(input logic [MAX_INPUTS-1:0] oh);
      logic [2:0] idx;
      idx = '0;
      for (int i = 0; i < MAX_INPUTS; i++)
         if (oh[i]) idx = idx | 3'(i);
      return idx;
   endfunction

endpackage

// File: rtl/noc_rr_select.sv
// noc_rr_select: combinational round-robin pick, searching upward from ptr+1 with wrap.
//    req    - request vector
//    ptr    - last served index (lowest priority this round)
//    winner - one-hot selected request, zero when none
//    any    - at least one request present
module noc_rr_select #(
   parameter int N  = 4,
   parameter int PW = $clog2(N)
) (
   input  logic [N-1:0]  req,
   input  logic [PW-1:0] ptr,
   output logic [N-1:0]  winner,
   output logic          any
);

   always_comb begin
      logic          found;
      logic [PW-1:0] idx;
      winner = '0;
      found  = 1'b0;
      for (int k = 1; k <= N; k++) begin
         idx = PW'((int'(ptr) + k) % N);
         if (!found && req[idx]) begin
            winner[idx] = 1'b1;
            found       = 1'b1;
         end
      end
   end

   assign any = |req;

endmodule

// File: rtl/noc_output_arbiter.sv
// noc_output_arbiter: round-robin, packet-locked (wormhole) arbiter feeding a one-entry output register.
//    clk, rst                    - rising-edge clock, asynchronous active-high reset
//    in_flit/in_last/in_valid    - per-port request flits, last markers and valids
//    in_ready                    - per-port acceptance, combinational
//    out_flit/out_last/out_valid - registered output stage, out_ready from downstream
//    grant                       - one-hot owner while a packet holds the lock
//    busy                        - locked or output register occupied
//    pkt_count                   - completed packets, wrapping
module noc_output_arbiter
   import noc_arb_pkg::*;
#(
   parameter int INPUTS     = 4,
   parameter int FLIT_WIDTH = 32,
   parameter int CNT_WIDTH  = 16
) (
   input  logic                         clk,
   input  logic                         rst,
   input  logic [INPUTS*FLIT_WIDTH-1:0] in_flit,
   input  logic [INPUTS-1:0]            in_last,
   input  logic [INPUTS-1:0]            in_valid,
   output logic [INPUTS-1:0]            in_ready,
   output logic [FLIT_WIDTH-1:0]        out_flit,
   output logic                         out_last,
   output logic                         out_valid,
   input  logic                         out_ready,
   output logic [INPUTS-1:0]            grant,
   output logic                         busy,
   output logic [CNT_WIDTH-1:0]         pkt_count
);

   localparam int PW = $clog2(INPUTS);

   arb_state_t state, state_next;
   logic [PW-1:0] ptr, owner, sel_idx;
   logic [INPUTS-1:0] winner, owner_oh, xfer_oh;
   logic accept, any, xfer, sel_last;
   logic [FLIT_WIDTH-1:0] sel_flit;

   noc_rr_select #(.N(INPUTS), .PW(PW)) u_sel (
      .req    (in_valid),
      .ptr    (ptr),
      .winner (winner),
      .any    (any)
   );

   assign accept   = !out_valid || out_ready;
   assign owner_oh = INPUTS'(1) << owner;

   // rst gates in_ready so nothing is taken while the block is held in reset.
   assign in_ready = rst ? '0 : !accept ? '0 : (state == LOCKED) ? owner_oh : (any ? winner : '0);

   assign xfer_oh  = in_ready & in_valid;
   assign xfer     = |xfer_oh;
   assign sel_idx  = PW'(onehot_to_idx(8'(xfer_oh)));
   assign sel_flit = in_flit[sel_idx*FLIT_WIDTH +: FLIT_WIDTH];
   assign sel_last = in_last[sel_idx];

   assign grant = (state == LOCKED) ? owner_oh : '0;
   assign busy  = (state == LOCKED) || out_valid;

   always_comb begin
      state_next = state;
      if (xfer) state_next = sel_last ? IDLE : LOCKED;
   end

   always_ff @(posedge clk or posedge rst) begin
      if (rst) state <= IDLE;
      else     state <= state_next;
   end

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         ptr       <= PW'(INPUTS - 1);
         owner     <= '0;
         out_flit  <= '0;
         out_last  <= 1'b0;
         out_valid <= 1'b0;
         pkt_count <= '0;
      end else begin
         if (xfer) begin
            out_flit  <= sel_flit;
            out_last  <= sel_last;
            out_valid <= 1'b1;
         end else if (out_ready) begin
            out_valid <= 1'b0;
         end
         if (xfer && state == IDLE) owner <= sel_idx;
         if (xfer && sel_last) begin
            ptr       <= sel_idx;
            pkt_count <= pkt_count + 1'b1;
         end
      end
   end

endmodule

// File: tb/tb_noc_output_arbiter.sv
// tb_noc_output_arbiter: directed self-checking bench for noc_output_arbiter (4 ports, 32-bit flits).
module tb_noc_output_arbiter;

   logic         clk, rst;
   logic [127:0] in_flit;
   logic [3:0]   in_last, in_valid, in_ready, grant;
   logic [31:0]  out_flit;
   logic         out_last, out_valid, out_ready, busy;
   logic [15:0]  pkt_count;
   int checks   = 0;
   int failures = 0;

   noc_output_arbiter dut (
      .clk       (clk),
      .rst       (rst),
      .in_flit   (in_flit),
      .in_last   (in_last),
      .in_valid  (in_valid),
      .in_ready  (in_ready),
      .out_flit  (out_flit),
      .out_last  (out_last),
      .out_valid (out_valid),
      .out_ready (out_ready),
      .grant     (grant),
      .busy      (busy),
      .pkt_count (pkt_count)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   task automatic tick();
      @(posedge clk);
      #1;
   endtask

   task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      checks++;
      assert (obs === exp) else begin
         failures++;
         $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
      end
   endtask

   task automatic set_port(input int p, input logic [31:0] f, input logic l);
      in_flit[p*32 +: 32] = f;
      in_last[p]          = l;
   endtask

   initial begin
      rst = 1'b1; in_flit = '0; in_last = '0; in_valid = 4'b1111; out_ready = 1'b1;
      #2;
      chk("rst_in_ready", 32'(in_ready), 0);
      chk("rst_out_valid", 32'(out_valid), 0);
      chk("rst_out_flit", out_flit, 0);
      chk("rst_grant", 32'(grant), 0);
      chk("rst_busy", 32'(busy), 0);
      chk("rst_pkt_count", 32'(pkt_count), 0);
      tick(); tick();
      rst = 1'b0;
      // single-flit packets on all ports: rotation 0,1,2,3,0
      for (int p = 0; p < 4; p++) set_port(p, 32'hA0 + 32'(p), 1'b1);
      for (int k = 0; k < 5; k++) begin
         #1;
         chk("rr_in_ready", 32'(in_ready), 32'(4'b0001 << (k % 4)));
         tick();
         chk("rr_out_flit", out_flit, 32'hA0 + 32'(k % 4));
         chk("rr_out_valid", 32'(out_valid), 1);
         chk("rr_pkt_count", 32'(pkt_count), 32'(k + 1));
      end
      in_valid = 4'b0000;
      #1;
      chk("idle_in_ready", 32'(in_ready), 0);
      tick();
      chk("drain_out_valid", 32'(out_valid), 0);
      chk("idle_pkt_count", 32'(pkt_count), 5);
      chk("idle_busy", 32'(busy), 0);
      // port 2 three-flit packet locks out port 0
      set_port(2, 32'h2A0A, 1'b0);
      set_port(0, 32'h0F00, 1'b1);
      in_valid = 4'b0101;
      #1;
      chk("lock_arb_in_ready", 32'(in_ready), 32'(4'b0100));
      tick();
      chk("lock_flit_a", out_flit, 32'h2A0A);
      chk("lock_grant_1", 32'(grant), 32'(4'b0100));
      chk("lock_busy", 32'(busy), 1);
      set_port(2, 32'h2B0B, 1'b0);
      #1;
      chk("lock_in_ready_b", 32'(in_ready), 32'(4'b0100));
      tick();
      chk("lock_flit_b", out_flit, 32'h2B0B);
      chk("lock_grant_2", 32'(grant), 32'(4'b0100));
      set_port(2, 32'h2C0C, 1'b1);
      #1;
      chk("lock_in_ready_c", 32'(in_ready), 32'(4'b0100));
      tick();
      chk("lock_flit_c", out_flit, 32'h2C0C);
      chk("lock_last_c", 32'(out_last), 1);
      chk("lock_grant_end", 32'(grant), 0);
      chk("lock_pkt_count", 32'(pkt_count), 6);
      in_valid = 4'b0001;
      #1;
      chk("after_lock_in_ready", 32'(in_ready), 32'(4'b0001));
      tick();
      chk("after_lock_flit", out_flit, 32'h0F00);
      chk("after_lock_pkt_count", 32'(pkt_count), 7);
      // backpressure mid-packet from port 1
      in_valid = 4'b0010;
      set_port(1, 32'h100, 1'b0);
      #1;
      chk("bp_in_ready_0", 32'(in_ready), 32'(4'b0010));
      tick();
      chk("bp_flit_0", out_flit, 32'h100);
      set_port(1, 32'h101, 1'b0);
      out_ready = 1'b0;
      for (int k = 0; k < 4; k++) begin
         #1;
         chk("bp_stall_in_ready", 32'(in_ready), 0);
         tick();
         chk("bp_stall_flit", out_flit, 32'h100);
         chk("bp_stall_valid", 32'(out_valid), 1);
      end
      out_ready = 1'b1;
      for (int k = 1; k < 4; k++) begin
         set_port(1, 32'h100 + 32'(k), k == 3);
         #1;
         chk("bp_resume_in_ready", 32'(in_ready), 32'(4'b0010));
         tick();
         chk("bp_resume_flit", out_flit, 32'h100 + 32'(k));
         chk("bp_resume_valid", 32'(out_valid), 1);
      end
      chk("bp_pkt_count", 32'(pkt_count), 8);
      in_valid = 4'b0000;
      tick();
      chk("bp_drain_valid", 32'(out_valid), 0);
      // reset in the middle of a 4-flit packet from port 1
      in_valid = 4'b0010;
      set_port(1, 32'h200, 1'b0);
      #1;
      chk("mid_rst_in_ready", 32'(in_ready), 32'(4'b0010));
      tick();
      set_port(1, 32'h201, 1'b0);
      tick();
      chk("mid_rst_flit2", out_flit, 32'h201);
      chk("mid_rst_grant", 32'(grant), 32'(4'b0010));
      rst = 1'b1;
      #1;
      chk("mid_rst_out_valid", 32'(out_valid), 0);
      chk("mid_rst_out_flit", out_flit, 0);
      chk("mid_rst_grant0", 32'(grant), 0);
      chk("mid_rst_busy", 32'(busy), 0);
      chk("mid_rst_in_ready0", 32'(in_ready), 0);
      chk("mid_rst_pkt_count", 32'(pkt_count), 0);
      tick();
      rst = 1'b0;
      in_valid = 4'b1111;
      in_last  = 4'b1111;
      set_port(0, 32'h0E0E, 1'b1);
      #1;
      chk("post_rst_in_ready", 32'(in_ready), 32'(4'b0001));
      tick();
      chk("post_rst_flit", out_flit, 32'h0E0E);
      chk("post_rst_pkt_count", 32'(pkt_count), 1);
      // packet counter wrap
      rst = 1'b1;
      tick();
      rst = 1'b0;
      in_valid = 4'b0001;
      for (int k = 0; k < 65535; k++) tick();
      chk("wrap_preset", 32'(pkt_count), 32'hFFFF);
      tick();
      chk("wrap_zero", 32'(pkt_count), 0);
      $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
      $finish;
   end

endmodule
